// File: rtl/rom_loader.sv
// rom_loader: turns the system ROM byte stream into 16-bit writes to the core's
// ROM memory port.
//
// Optional header bytes are dropped, payload bytes are packed little-endian
// into words ({odd byte, even byte}), and words are staged in a small FIFO.
// The FIFO is drained one word at a time over a we/ready handshake.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   rom_loading         high for the duration of a ROM transfer
//   rom_do/rom_do_valid ROM byte and its one-cycle strobe
//   mem_addr/mem_din    word address and data of the current write
//   mem_we/mem_ready    write request (held) / write accepted
//   busy                loader is not idle
//   loading_done        one-cycle pulse once every word has been written
//   rom_size            payload bytes accepted (header excluded), saturating
//   overflow            sticky: a word was lost on a full FIFO
//   checksum            (only with ROM_CHECKSUM_EN) 16-bit sum of payload bytes
//
// Build option: define ROM_CHECKSUM_EN to add the checksum port and adder.
module rom_loader #(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned HEADER_SKIP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              loading_done,
  output logic [ADDR_W+1:0] rom_size,
  output logic              overflow
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SKIP_W = $clog2(HEADER_SKIP + 2);
  localparam int unsigned SIZE_W = ADDR_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  state_t            state;
  logic [SKIP_W-1:0] skip_cnt;
  logic              phase;
  logic [7:0]        low_byte;

  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              take;
  logic              in_header;
  logic              payload;
  logic              load_end;
  logic              pop;
  logic              full;
  logic              push_req;
  logic              push_ok;
  logic [15:0]       push_data;

  assign take      = (state == LOAD) && rom_do_valid;
  assign in_header = (skip_cnt != SKIP_W'(HEADER_SKIP));
  assign payload   = take && !in_header;
  assign load_end  = (state == LOAD) && !rom_loading;
  assign pop       = (state != IDLE) && !mem_we && (count != '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok   = push_req && (!full || pop);

  // At most one push per cycle: a completed pair, or the padded final byte when
  // the transfer ends (including an even byte arriving on the closing cycle).
  always_comb begin
    push_req  = 1'b0;
    push_data = '0;
    if (payload && phase) begin
      push_req  = 1'b1;
      push_data = {rom_do, low_byte};
    end else if (load_end && payload) begin
      push_req  = 1'b1;
      push_data = {8'h00, rom_do};
    end else if (load_end && phase) begin
      push_req  = 1'b1;
      push_data = {8'h00, low_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      skip_cnt     <= '0;
      phase        <= 1'b0;
      low_byte     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      mem_addr     <= '0;
      mem_din      <= '0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      loading_done <= 1'b0;
      rom_size     <= '0;
      overflow     <= 1'b0;
`ifdef ROM_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      loading_done <= 1'b0;

      case (state)
        IDLE: begin
          if (rom_loading) begin
            state    <= LOAD;
            busy     <= 1'b1;
            skip_cnt <= '0;
            phase    <= 1'b0;
            mem_addr <= '0;
            rom_size <= '0;
            overflow <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        LOAD: begin
          if (take) begin
            if (in_header) begin
              skip_cnt <= skip_cnt + SKIP_W'(1);
            end else begin
              phase <= ~phase;
              if (!phase) begin
                low_byte <= rom_do;
              end
              if (rom_size != '1) begin
                rom_size <= rom_size + SIZE_W'(1);
              end
`ifdef ROM_CHECKSUM_EN
              checksum <= checksum + 16'(rom_do);
`endif
            end
          end
          if (!rom_loading) begin
            state <= FLUSH;
            phase <= 1'b0;
          end
        end
        FLUSH: begin
          if (count == '0 && !mem_we) begin
            state        <= DONE;
            loading_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        mem_din <= fifo_mem[rd_ptr];
        mem_we  <= 1'b1;
      end else if (mem_we && mem_ready) begin
        mem_we   <= 1'b0;
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push_ok) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule
